osc_freq_meter: RTL



---
 rtl/osc_freq_meter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/osc_freq_meter.sv
// Gated rising-edge counter for a slow asynchronous input, with presence and lock status.
// Optional FREQ_METER_MINMAX_EN adds cnt_min/cnt_max tracking over non-overflow windows.
module osc_freq_meter #(
  parameter int GATE_CYCLES    = 62500,
  parameter int CNT_W          = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TOL            = 2,
  parameter int STABLE_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow,
  output logic             present,
  output logic             locked
`ifdef FREQ_METER_MINMAX_EN
  ,
  output logic [CNT_W-1:0] cnt_min,
  output logic [CNT_W-1:0] cnt_max
`endif
);

  // state  | meaning
  // IDLE   | measurement off, counters held at zero
  // GATE   | counting edges for GATE_CYCLES clocks
  // REPORT | one cycle: publish count, update lock, edges dropped

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int SW = $clog2(STABLE_WINDOWS + 1);
  localparam logic [GW-1:0]    GATE_LAST  = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0]    STABLE_MAX = SW'(STABLE_WINDOWS);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W:0]   TOL_W      = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {IDLE, GATE, REPORT} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   edge_q;
  logic [GW-1:0]          gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   ovf;
  logic [CNT_W-1:0]       prev_cnt;
  logic                   prev_valid;
  logic [SW-1:0]          stable_cnt, stable_nxt;
  logic [CNT_W:0]         diff, diff_abs;
  logic                   match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sync_prev <= sync_q[SYNC_STAGES-1];
      edge_q    <= sync_q[SYNC_STAGES-1] & ~sync_prev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = GATE;
      GATE: begin
        if (!en)                         state_nxt = IDLE;
        else if (gate_cnt == GATE_LAST)  state_nxt = REPORT;
      end
      REPORT:  state_nxt = en ? GATE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign count_valid = (state == REPORT);

  // Difference kept one bit wider than the count so the sign is never lost.
  always_comb begin
    diff       = {1'b0, edge_cnt} - {1'b0, prev_cnt};
    diff_abs   = diff[CNT_W] ? (~diff + 1'b1) : diff;
    match      = prev_valid & ~ovf & (edge_cnt != '0) & (diff_abs <= TOL_W);
    stable_nxt = '0;
    if (match) stable_nxt = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
      present    <= 1'b0;
      locked     <= 1'b0;
      prev_cnt   <= '0;
      prev_valid <= 1'b0;
      stable_cnt <= '0;
    end else begin
      case (state)
        GATE: begin
          if (!en) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            overflow   <= 1'b0;
            present    <= 1'b0;
            locked     <= 1'b0;
            prev_valid <= 1'b0;
            stable_cnt <= '0;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            if (edge_q) begin
              if (edge_cnt == CNT_MAX) ovf <= 1'b1;
              else                     edge_cnt <= edge_cnt + 1'b1;
            end
          end
        end
        REPORT: begin
          count      <= edge_cnt;
          overflow   <= ovf;
          present    <= (edge_cnt != '0);
          stable_cnt <= stable_nxt;
          locked     <= (stable_nxt == STABLE_MAX);
          prev_cnt   <= edge_cnt;
          prev_valid <= 1'b1;
          gate_cnt   <= '0;
          edge_cnt   <= '0;
          ovf        <= 1'b0;
        end
        default: begin
          gate_cnt   <= '0;
          edge_cnt   <= '0;
          ovf        <= 1'b0;
          overflow   <= 1'b0;
          present    <= 1'b0;
          locked     <= 1'b0;
          prev_valid <= 1'b0;
          stable_cnt <= '0;
        end
      endcase
    end
  end

`ifdef FREQ_METER_MINMAX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_min <= '1;
      cnt_max <= '0;
    end else if (state == IDLE && en) begin
      cnt_min <= '1;
      cnt_max <= '0;
    end else if (state == REPORT && !ovf) begin
      if (edge_cnt < cnt_min) cnt_min <= edge_cnt;
      if (edge_cnt > cnt_max) cnt_max <= edge_cnt;
    end
  end
`endif

endmodule
